// File: rtl/qpsk_mod.sv
// QPSK mapper: double-buffers interleaved coded blocks and streams one
// Gray-mapped I/Q symbol per handshake, two coded bits per symbol.
module qpsk_mod #(
    parameter int                    Ncbps = 192,
    parameter int                    Ncpc  = 2,
    parameter int                    W     = 16,
    parameter logic signed [W-1:0]   AMP   = 16'sd23170
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [Ncbps-1:0]    data_in,
    input  logic                valid_in,
    output logic                ready_mod,
    input  logic                ready_in,
    output logic signed [W-1:0] i_out,
    output logic signed [W-1:0] q_out,
    output logic                valid_out,
    output logic                last_out
);
    localparam int              Nsym = Ncbps / Ncpc;
    localparam int              CW   = $clog2(Nsym);
    localparam int              BW   = CW + 1;
    localparam logic [CW-1:0]   LAST = CW'(Nsym - 1);
    localparam logic signed [W-1:0] POS = AMP;
    localparam logic signed [W-1:0] NEG = -AMP;

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state, state_next;
    logic [Ncbps-1:0]     blk_buf [2];
    logic                 wr_ptr, rd_ptr;
    logic [1:0]           occ;
    logic [CW-1:0]        sym_cnt, cnt_next;
    logic                 valid_next, last_next, load;
    logic signed [W-1:0]  i_next, q_next;
    logic [Ncbps-1:0]     src;
    logic [BW-1:0]        i_idx, q_idx;
    logic                 accept, hs, last_hs;

    assign ready_mod = (occ != 2'd2);
    assign accept    = valid_in && ready_mod;
    assign hs        = valid_out && ready_in;
    assign last_hs   = hs && (sym_cnt == LAST);

    // When the last symbol leaves with only one block held, a block accepted
    // on the same edge is read straight from data_in so no bubble appears.
    always_comb begin
        state_next = state;
        cnt_next   = sym_cnt;
        valid_next = valid_out;
        i_next     = i_out;
        q_next     = q_out;
        load       = 1'b0;
        src        = blk_buf[rd_ptr];
        case (state)
            IDLE: begin
                if (occ != 2'd0) begin
                    state_next = SEND;
                    cnt_next   = '0;
                    valid_next = 1'b1;
                    load       = 1'b1;
                end
            end
            SEND: begin
                if (hs) begin
                    if (!last_hs) begin
                        cnt_next = sym_cnt + CW'(1);
                        load     = 1'b1;
                    end else if (occ == 2'd2 || accept) begin
                        cnt_next = '0;
                        load     = 1'b1;
                        src      = (occ == 2'd2) ? blk_buf[~rd_ptr] : data_in;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        valid_next = 1'b0;
                        i_next     = '0;
                        q_next     = '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        i_idx = {cnt_next, 1'b0};
        q_idx = {cnt_next, 1'b1};
        if (load) begin
            i_next = src[i_idx] ? NEG : POS;
            q_next = src[q_idx] ? NEG : POS;
        end
        last_next = valid_next && (cnt_next == LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_cnt   <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occ       <= 2'd0;
        end else begin
            sym_cnt   <= cnt_next;
            valid_out <= valid_next;
            last_out  <= last_next;
            i_out     <= i_next;
            q_out     <= q_next;
            if (accept)  wr_ptr <= ~wr_ptr;
            if (last_hs) rd_ptr <= ~rd_ptr;
            case ({accept, last_hs})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Block storage carries no reset; occupancy alone says what is live.
    always_ff @(posedge clk) begin
        if (accept) blk_buf[wr_ptr] <= data_in;
    end
endmodule

// File: doc/qpsk_mod.md
QPSK_MOD -- requirements
Module: qpsk_mod

Parameters
REQ-001 SHALL have parameter Ncbps, default 192, coded bits per block.
REQ-002 SHALL have parameter Ncpc, default 2, coded bits per carrier (QPSK); Nsym = Ncbps/Ncpc = 96.
REQ-003 SHALL have parameter W, default 16, I/Q sample width, signed Q1.15.
REQ-004 SHALL have parameter AMP, default 16'sd23170 (0.7071 in Q1.15), constellation amplitude.

Interface
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 data_in  input  Ncbps  interleaved block from upstream interleaver.
REQ-008 valid_in  input  1  data_in holds a complete block.
REQ-009 ready_mod  output  1  block buffer can accept a block this cycle.
REQ-010 ready_in  input  1  downstream (IFFT/subcarrier mapper) accepts a symbol.
REQ-011 i_out  output  W  signed in-phase sample.
REQ-012 q_out  output  W  signed quadrature sample.
REQ-013 valid_out  output  1  i_out/q_out/last_out valid.
REQ-014 last_out  output  1  marks symbol Nsym-1 of a block.

Function
REQ-015 Block transfer SHALL occur on a rising edge where valid_in=1 and ready_mod=1; otherwise data_in ignored.
REQ-016 SHALL contain a two-entry ping-pong block buffer with write pointer, read pointer and 2-bit occupancy count (0..2).
REQ-017 ready_mod SHALL be 1 when occupancy < 2, combinationally independent of valid_in.
REQ-018 Symbol n (0..Nsym-1) SHALL use b0 = block[2n], b1 = block[2n+1].
REQ-019 Mapping SHALL be b0=0 -> i_out=+AMP, b0=1 -> i_out=-AMP; b1=0 -> q_out=+AMP, b1=1 -> q_out=-AMP.
REQ-020 FSM SHALL have states IDLE and SEND.
REQ-021 IDLE -> SEND when occupancy > 0; symbol counter loaded to 0; first symbol presented registered, one cycle after the accepting edge (latency 1 clk, valid_in edge to valid_out=1).
REQ-022 In SEND, output SHALL advance on each edge with valid_out=1 and ready_in=1; outputs SHALL hold stable while ready_in=0.
REQ-023 last_out SHALL be 1 only while symbol counter = Nsym-1 and valid_out=1.
REQ-024 On handshake of last symbol: read pointer toggles, occupancy decrements; if another block is buffered, symbol 0 of that block SHALL appear next cycle (no bubble), else FSM -> IDLE, valid_out=0.
REQ-025 Simultaneous block accept and last-symbol handshake SHALL leave occupancy unchanged, both pointers toggled.
REQ-026 Accepting a block SHALL never overwrite the entry being read.
REQ-027 Symbol counter SHALL wrap Nsym-1 -> 0; width $clog2(Nsym).
REQ-028 Sustained throughput SHALL be one symbol per clock when ready_in=1.

Reset
REQ-029 reset=1 SHALL immediately clear: valid_out=0, last_out=0, i_out=0, q_out=0, occupancy=0, pointers=0, counter=0, FSM=IDLE; ready_mod=1 after reset.
REQ-030 Reset asserted mid-block SHALL discard all buffered data; no partial block resumes after release.
REQ-031 Buffer data contents need no reset.

Verification
REQ-032 Single block all zeros, ready_in=1 -> 96 symbols (+23170,+23170), valid_out high 96 consecutive cycles, last_out only on 96th, first valid one cycle after accept.
REQ-033 data_in=192'h...AAAA (odd bits 1) -> every symbol (+23170,-23170); data_in=all ones -> (-23170,-23170).
REQ-034 Three blocks back-to-back, valid_in held high, ready_in=1 -> ready_mod drops to 0 after two accepts, 288 contiguous symbols, no bubble at block boundaries.
REQ-035 ready_in toggled pseudo-randomly -> symbol sequence identical to REQ-032/033 references, outputs stable while ready_in=0.
REQ-036 Block accepted on same edge as last-symbol handshake -> occupancy unchanged, next block starts next cycle.
REQ-037 reset pulsed at symbol 40 -> outputs zero same cycle, valid_out=0 until a new block is accepted, which then streams from symbol 0.
